sprite_blit_ctrl: RTL and testbench
===================================

// Module: sprite_blit_ctrl
// PURPOSE
//   Command-driven sequencer that owns the write port of the frame RAM. Executes two ops:
//   CLEAR (fill whole frame with one colour) and BLIT (copy a WxH sprite rectangle from a
//   sync-read sprite ROM into the frame at (x,y), with transparency and edge clipping).
//   Sits between game logic (command source) and the frame RAM (we/write_address/data_In).
// PARAMETERS
//   FB_W     20    frame width in pixels
//   FB_H     20    frame height in pixels (FB_W*FB_H <= 2**ADDR_W)
//   ADDR_W   19    frame RAM / sprite ROM address width
//   DATA_W   4     pixel (palette index) width
//   COORD_W  5     width of x, y, w, h command fields
//   TRANSP   0     palette index treated as transparent during BLIT
// PORTS
//   Clk        in   1        system clock, all logic on posedge
//   Reset      in   1        synchronous, active-high
//   cmd_valid  in   1        command offered
//   cmd_ready  out  1        controller idle, command accepted when valid&ready
//   cmd_op     in   1        0 = CLEAR, 1 = BLIT
//   cmd_x/y    in   COORD_W  BLIT destination top-left
//   cmd_w/h    in   COORD_W  BLIT sprite width/height
//   cmd_color  in   DATA_W   CLEAR fill colour
//   spr_base   in   ADDR_W   sprite ROM address of sprite pixel (0,0), row-major
//   src_addr   out  ADDR_W   sprite ROM read address
//   src_data   in   DATA_W   sprite ROM data, valid 1 cycle after src_addr
//   fb_we      out  1        frame RAM write enable
//   fb_addr    out  ADDR_W   frame RAM write address
//   fb_data    out  DATA_W   frame RAM write data
//   busy       out  1        op in progress (== ~cmd_ready)
//   done       out  1        1-cycle pulse at op completion
// BEHAVIOUR
//   Reset: state IDLE; cmd_ready=1, busy=0, done=0, fb_we=0, fb_addr=0, fb_data=0, src_addr=0.
//   All cmd_* fields latched on accept; inputs ignored while busy (cmd_ready=0).
//   FSM: IDLE -> CLEAR | BLIT | DONE (accept); CLEAR -> DONE; BLIT -> DRAIN -> DONE; DONE -> IDLE.
//   CLEAR: starting cycle after accept, one write per cycle, fb_addr = 0..FB_W*FB_H-1 ascending,
//     fb_data = cmd_color, fb_we=1 every cycle; then DONE.
//   BLIT: issue phase of w*h cycles, index k = row*w+col row-major; src_addr = spr_base+k.
//     Write slot for k is the cycle after its issue (ROM latency 1): fb_we=1 only if
//     src_data != TRANSP and (x+col) < FB_W and (y+row) < FB_H; fb_addr = (y+row)*FB_W+(x+col),
//     fb_data = src_data. Coordinate sums computed COORD_W+1 wide (no wrap). DRAIN covers the
//     last slot. Clipped/transparent slots still consume their cycle.
//   Zero-size BLIT (w==0 or h==0): no reads, no writes; IDLE -> DONE directly.
//   DONE: done=1 for exactly one cycle, fb_we=0; cmd_ready returns high the following cycle.
//   Latency: CLEAR accept@t -> writes t+1..t+N, done@t+N+1. BLIT accept@t -> first read t+1,
//     first write slot t+2, last slot t+1+w*h, done@t+2+w*h.
//   fb_we is never 1 in IDLE or DONE; at most one write per cycle.
//   Reset mid-op: op aborted, no further writes (fb_we=0 the next cycle), no done pulse.
// TESTING
//   CLEAR color=5 accepted @t -> 400 writes addr 0..399 data 5 on t+1..t+400, done@t+401 only.
//   BLIT x=2,y=1,w=3,h=2,base=100, ROM data nonzero -> src_addr 100..105, writes 22,23,24,42,43,44.
//   BLIT with ROM[101]=0 (TRANSP) -> slot for addr 23 has fb_we=0, other five writes present.
//   BLIT x=18,y=19,w=4,h=2 -> only addr 398,399 written; done still @t+2+8.
//   cmd_valid held high during busy -> second command accepted only the cycle after done.
//   Reset asserted mid-CLEAR -> fb_we=0 next cycle, cmd_ready=1, done never pulses.

Source files
------------

// File: rtl/sprite_blit_ctrl.sv
// sprite_blit_ctrl
//   Command sequencer that owns the frame RAM write port. It runs two operations:
//     CLEAR : fill the whole FB_W x FB_H frame with cmd_color, one pixel per cycle.
//     BLIT  : copy a w x h sprite, stored row-major in a sync-read ROM at spr_base, to
//             frame position (x,y). Pixels equal to TRANSP are skipped, and pixels that
//             land outside the frame are clipped. Skipped and clipped pixels still use
//             their cycle.
//
// Handshake: a command is accepted on any rising edge where cmd_valid && cmd_ready.
//   cmd_ready is high only in IDLE, and all cmd_* fields and spr_base are captured on
//   that edge. cmd_valid and the fields are don't-care while busy. done pulses for one
//   cycle when an op ends, and cmd_ready rises on the following cycle.
//
// Ports
//   Clk, Reset                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op                      0 = CLEAR, 1 = BLIT
//   cmd_x/y/w/h, cmd_color      command fields
//   spr_base                    sprite ROM address of sprite pixel (0,0)
//   src_addr / src_data         sprite ROM read port (data valid 1 cycle after address)
//   fb_we / fb_addr / fb_data   frame RAM write port
//   busy, done                  status; busy == ~cmd_ready, done is a 1-cycle pulse
//   state_dbg                   current FSM state, for observation only
module sprite_blit_ctrl #(
  parameter int FB_W    = 20,
  parameter int FB_H    = 20,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 4,
  parameter int COORD_W = 5,
  parameter int TRANSP  = 0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic [DATA_W-1:0]  cmd_color,
  input  logic [ADDR_W-1:0]  spr_base,
  output logic [ADDR_W-1:0]  src_addr,
  input  logic [DATA_W-1:0]  src_data,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [DATA_W-1:0]  fb_data,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_BLIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0]  LAST_PIX = ADDR_W'(FB_W * FB_H - 1);
  localparam logic [COORD_W:0]   FB_W_C   = (COORD_W + 1)'(FB_W);
  localparam logic [COORD_W:0]   FB_H_C   = (COORD_W + 1)'(FB_H);
  localparam logic [DATA_W-1:0]  TRANSP_C = DATA_W'(TRANSP);

  state_t state, state_d;

  logic [COORD_W-1:0] x_q, y_q, w_q, h_q;
  logic [DATA_W-1:0]  color_q;
  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W-1:0]  cnt;       // CLEAR pixel address, or BLIT issue index k
  logic [COORD_W-1:0] col, row;  // BLIT position of index k inside the sprite

  // One-deep write slot: the address and clip result of the pixel issued last cycle.
  // Its ROM data arrives this cycle on src_data.
  logic               pend;
  logic [ADDR_W-1:0]  slot_addr;
  logic               slot_inb;

  logic               last_issue;
  logic [COORD_W:0]   dx, dy;    // one bit wider so the sums cannot wrap
  logic               in_bounds;
  logic [ADDR_W-1:0]  pix_addr;

  always_comb begin
    last_issue = (col == w_q - COORD_W'(1)) && (row == h_q - COORD_W'(1));
    dx         = {1'b0, x_q} + {1'b0, col};
    dy         = {1'b0, y_q} + {1'b0, row};
    in_bounds  = (dx < FB_W_C) && (dy < FB_H_C);
    pix_addr   = ADDR_W'(dy) * ADDR_W'(FB_W) + ADDR_W'(dx);
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (!cmd_op)                             state_d = S_CLEAR;
          else if (cmd_w == '0 || cmd_h == '0)     state_d = S_DONE;
          else                                     state_d = S_BLIT;
        end
      end
      S_CLEAR: if (cnt == LAST_PIX) state_d = S_DONE;
      S_BLIT:  if (last_issue)      state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      base_q    <= '0;
      cnt       <= '0;
      col       <= '0;
      row       <= '0;
      pend      <= 1'b0;
      slot_addr <= '0;
      slot_inb  <= 1'b0;
    end else begin
      state <= state_d;
      if (state == S_IDLE && cmd_valid) begin
        x_q     <= cmd_x;
        y_q     <= cmd_y;
        w_q     <= cmd_w;
        h_q     <= cmd_h;
        color_q <= cmd_color;
        base_q  <= spr_base;
        cnt     <= '0;
        col     <= '0;
        row     <= '0;
      end else if (state == S_CLEAR) begin
        cnt <= cnt + ADDR_W'(1);
      end else if (state == S_BLIT) begin
        cnt <= cnt + ADDR_W'(1);
        if (col == w_q - COORD_W'(1)) begin
          col <= '0;
          row <= row + COORD_W'(1);
        end else begin
          col <= col + COORD_W'(1);
        end
      end
      pend      <= (state == S_BLIT);
      slot_addr <= pix_addr;
      slot_inb  <= in_bounds;
    end
  end

  // Outputs. pend is only ever set in BLIT or DRAIN, so IDLE and DONE never write.
  always_comb begin
    cmd_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    state_dbg = state;
    src_addr  = '0;
    fb_we     = 1'b0;
    fb_addr   = '0;
    fb_data   = '0;
    if (state == S_BLIT) src_addr = base_q + cnt;
    if (state == S_CLEAR) begin
      fb_we   = 1'b1;
      fb_addr = cnt;
      fb_data = color_q;
    end else if (pend) begin
      fb_we   = slot_inb && (src_data != TRANSP_C);
      fb_addr = slot_addr;
      fb_data = src_data;
    end
  end

endmodule

// File: tb/tb_sprite_blit_ctrl.sv
module tb_sprite_blit_ctrl;

  localparam int FB_W    = 20;
  localparam int FB_H    = 20;
  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 4;
  localparam int COORD_W = 5;
  localparam int NPIX    = FB_W * FB_H;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               cmd_valid, cmd_ready, cmd_op;
  logic [COORD_W-1:0] cmd_x, cmd_y, cmd_w, cmd_h;
  logic [DATA_W-1:0]  cmd_color;
  logic [ADDR_W-1:0]  spr_base, src_addr, fb_addr;
  logic [DATA_W-1:0]  src_data, fb_data;
  logic               fb_we, busy, done;
  logic [2:0]         state_dbg;

  // Sprite ROM: 1-cycle synchronous read, indexed by the low address bits.
  logic [DATA_W-1:0] rom [0:1023];
  always @(posedge clk) src_data <= rom[src_addr[9:0]];

  sprite_blit_ctrl dut (
    .Clk(clk), .Reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .spr_base(spr_base),
    .src_addr(src_addr), .src_data(src_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  // Expected writes: {cycle after accept (16), address (19), data (4)}
  logic [38:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver + model ----------------
  // Call at a negedge with the DUT idle. Offers a command, builds the expected write
  // list from the op's rules, then checks every cycle up to and after done.
  // keep=1 holds cmd_valid high with scrambled fields while busy.
  task automatic run_cmd(input bit op, input int x, input int y, input int w, input int h,
                         input int color, input int base, input bit keep);
    int done_r, wh, row, col, px, py;
    logic [DATA_W-1:0] d;
    check_eq("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = COORD_W'(x);
    cmd_y     = COORD_W'(y);
    cmd_w     = COORD_W'(w);
    cmd_h     = COORD_W'(h);
    cmd_color = DATA_W'(color);
    spr_base  = ADDR_W'(base);
    @(posedge clk);  // accept edge

    exp_q.delete();
    wh = w * h;
    if (!op) begin
      for (int i = 0; i < NPIX; i++)
        exp_q.push_back({16'(i + 1), 19'(i), 4'(color)});
      done_r = NPIX + 1;
    end else begin
      for (int k = 0; k < wh; k++) begin
        row = k / w;
        col = k % w;
        px  = x + col;
        py  = y + row;
        d   = rom[(base + k) % 1024];
        if (d != 0 && px < FB_W && py < FB_H)
          exp_q.push_back({16'(k + 2), 19'(py * FB_W + px), d});
      end
      done_r = (wh == 0) ? 1 : wh + 2;
    end

    for (int r = 1; r <= done_r; r++) begin
      @(negedge clk);
      if (keep) begin
        cmd_op    = 1'($urandom_range(0, 1));
        cmd_x     = COORD_W'($urandom_range(0, 31));
        cmd_y     = COORD_W'($urandom_range(0, 31));
        cmd_w     = COORD_W'($urandom_range(0, 31));
        cmd_h     = COORD_W'($urandom_range(0, 31));
        cmd_color = DATA_W'($urandom_range(0, 15));
        spr_base  = ADDR_W'($urandom_range(0, 1000));
      end else begin
        cmd_valid = 1'b0;
      end
      check_eq("done_timing", done, (r == done_r));
      check_eq("ready_while_busy", cmd_ready, 0);
      check_eq("busy_while_busy", busy, 1);
      if (op && r <= wh) check_eq("src_addr", src_addr, 64'(base + r - 1));
      if (fb_we)
        check_eq("write", {16'(r), fb_addr, fb_data}, (exp_q.size() != 0) ? exp_q.pop_front() : 39'd0);
    end
    @(negedge clk);
    check_eq("ready_after_done", cmd_ready, 1);
    check_eq("we_after_done", fb_we, 0);
    check_eq("missing_writes", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    bit seen_done, seen_we;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
    cmd_color = '0;
    spr_base  = '0;
    for (int i = 0; i < 1024; i++) rom[i] = DATA_W'(1 + (i % 15));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_we", fb_we, 0);
    check_eq("rst_addr", fb_addr, 0);
    check_eq("rst_data", fb_data, 0);
    check_eq("rst_src", src_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    run_cmd(1'b0, 0, 0, 0, 0, 5, 0, 1'b0);        // full CLEAR, colour 5
    run_cmd(1'b1, 2, 1, 3, 2, 0, 100, 1'b0);      // writes 22,23,24,42,43,44
    rom[101] = '0;
    run_cmd(1'b1, 2, 1, 3, 2, 0, 100, 1'b0);      // addr 23 transparent
    rom[101] = 4'd2;
    run_cmd(1'b1, 18, 19, 4, 2, 0, 200, 1'b0);    // clipped: only 398, 399
    run_cmd(1'b1, 3, 3, 0, 5, 0, 10, 1'b0);       // zero width
    run_cmd(1'b1, 3, 3, 5, 0, 0, 10, 1'b0);       // zero height
    run_cmd(1'b1, 0, 0, 2, 2, 0, 300, 1'b1);      // valid held through busy
    run_cmd(1'b1, 5, 5, 3, 3, 0, 400, 1'b0);      // accepted the cycle after done

    // Randomized commands against the model
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom_range(1, 15));
    for (int n = 0; n < 25; n++) begin
      run_cmd(($urandom_range(0, 9) != 0), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 15),
              $urandom_range(0, 400000), (n != 24) && ($urandom_range(0, 1) == 1));
    end

    // Reset in the middle of a CLEAR
    run_cmd(1'b1, 1, 1, 1, 1, 0, 0, 1'b0);        // leaves bench at a clean idle negedge
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_color = 4'd9;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("clear_writing", {fb_we, fb_data}, {1'b1, 4'd9});
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_we", fb_we, 0);
    check_eq("midrst_ready", cmd_ready, 1);
    check_eq("midrst_done", done, 0);
    reset = 1'b0;
    seen_done = 1'b0;
    seen_we   = 1'b0;
    repeat (500) begin
      @(negedge clk);
      if (done)  seen_done = 1'b1;
      if (fb_we) seen_we   = 1'b1;
    end
    check_eq("no_done_after_rst", seen_done, 0);
    check_eq("no_we_after_rst", seen_we, 0);
    check_eq("idle_after_rst", cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
